// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz raster constants, FSM state type and small decode helpers
// used by the VGA timing generator and its counters.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int unsigned LOCK_SETTLE = 16;
    localparam int unsigned SETTLE_W    = $clog2(LOCK_SETTLE);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned REQ_X_W = 10;
    localparam int unsigned REQ_Y_W = 9;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2
    } vga_state_t;

    // Inclusive unsigned window test used for the sync pulse decode.
    function automatic logic in_window(input logic [CNT_W-1:0] val,
                                       input int unsigned      lo,
                                       input int unsigned      hi);
        return (val >= CNT_W'(lo)) && (val <= CNT_W'(hi));
    endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulus-N up counter with enable, synchronous clear and a combinational wrap
// pulse, so a second counter can be chained off the first one's wrap.
module wrap_counter #(
    parameter int unsigned N = 800,
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap = en && (cnt_q == LAST);
    assign cnt  = cnt_q;

    // Next count: clear wins, then wrap to zero, then advance when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (wrap) begin
            cnt_d = {W{1'b0}};
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480 @ 60 Hz raster generator gated on PLL lock: emits a pixel fetch request
// one cycle ahead of display enable, with syncs aligned to display enable.
module vga_timing_gen
    import vga_timing_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               locked,
    output logic               req_valid,
    output logic [REQ_X_W-1:0] req_x,
    output logic [REQ_Y_W-1:0] req_y,
    output logic               frame_start,
    output logic               de,
    output logic               hsync,
    output logic               vsync,
    output logic               running
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_SETTLE - 1);
    localparam logic [CNT_W-1:0]    H_ACT_C     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]    V_ACT_C     = CNT_W'(V_ACTIVE);

    vga_state_t          state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                running_q, running_d;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap_unused;
    logic             run_active;
    logic             cnt_clr;

    logic               req_valid_q, req_valid_d;
    logic [REQ_X_W-1:0] req_x_q, req_x_d;
    logic [REQ_Y_W-1:0] req_y_q, req_y_d;
    logic               frame_start_q, frame_start_d;
    logic               hs1_q, hs1_d;
    logic               vs1_q, vs1_d;

    logic de_q, de_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;

    // Lock sequencing: any low sample of locked drops straight back to WAIT_LOCK.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        if (!locked) begin
            state_d  = ST_WAIT_LOCK;
            settle_d = {SETTLE_W{1'b0}};
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    state_d  = ST_SETTLE;
                    settle_d = {SETTLE_W{1'b0}};
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        settle_d = settle_q + SETTLE_W'(1);
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d  = ST_WAIT_LOCK;
                    settle_d = {SETTLE_W{1'b0}};
                end
            endcase
        end
        running_d = (state_d == ST_RUN);
    end

    // FSM state, settle count and the registered running flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WAIT_LOCK;
            settle_q  <= {SETTLE_W{1'b0}};
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            running_q <= running_d;
        end
    end

    assign run_active = (state_q == ST_RUN);
    assign cnt_clr    = !locked || !run_active;

    wrap_counter #(.N(H_TOTAL), .W(CNT_W)) u_h_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (run_active),
        .clr  (cnt_clr),
        .cnt  (h_cnt),
        .wrap (h_wrap)
    );

    wrap_counter #(.N(V_TOTAL), .W(CNT_W)) u_v_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (h_wrap),
        .clr  (cnt_clr),
        .cnt  (v_cnt),
        .wrap (v_wrap_unused)
    );

    // Stage 1 decode: fetch request plus the sync decode carried one stage further.
    always_comb begin
        req_valid_d   = run_active && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        req_x_d       = {REQ_X_W{1'b0}};
        req_y_d       = {REQ_Y_W{1'b0}};
        frame_start_d = run_active && (h_cnt == {CNT_W{1'b0}}) && (v_cnt == {CNT_W{1'b0}});
        hs1_d         = !in_window(h_cnt, H_SYNC_START, H_SYNC_END);
        vs1_d         = !in_window(v_cnt, V_SYNC_START, V_SYNC_END);
        if (req_valid_d) begin
            req_x_d = h_cnt[REQ_X_W-1:0];
            req_y_d = v_cnt[REQ_Y_W-1:0];
        end else begin
            req_x_d = {REQ_X_W{1'b0}};
            req_y_d = {REQ_Y_W{1'b0}};
        end
        if (!locked) begin
            req_valid_d   = 1'b0;
            req_x_d       = {REQ_X_W{1'b0}};
            req_y_d       = {REQ_Y_W{1'b0}};
            frame_start_d = 1'b0;
            hs1_d         = 1'b1;
            vs1_d         = 1'b1;
        end else begin
            frame_start_d = frame_start_d && req_valid_d;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid_q   <= 1'b0;
            req_x_q       <= {REQ_X_W{1'b0}};
            req_y_q       <= {REQ_Y_W{1'b0}};
            frame_start_q <= 1'b0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
        end else begin
            req_valid_q   <= req_valid_d;
            req_x_q       <= req_x_d;
            req_y_q       <= req_y_d;
            frame_start_q <= frame_start_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
        end
    end

    // Stage 2 decode: display enable trails the request by exactly one cycle.
    always_comb begin
        if (!locked) begin
            de_d    = 1'b0;
            hsync_d = 1'b1;
            vsync_d = 1'b1;
        end else begin
            de_d    = req_valid_q;
            hsync_d = hs1_q;
            vsync_d = vs1_q;
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q    <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign req_valid   = req_valid_q;
    assign req_x       = req_x_q;
    assign req_y       = req_y_q;
    assign frame_start = frame_start_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign running     = running_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640×480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock produced by the board PLL, and gates itself on that PLL's `locked` indication. It sits directly downstream of the pixel-clock PLL and upstream of the frame-buffer reader and the VGA DAC pins. It issues a pixel-fetch request one cycle before each active pixel is displayed.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (cycles)
- `H_SYNC`, 96, hsync pulse width
- `H_BP`, 48, horizontal back porch; H_TOTAL = sum = 800
- `V_ACTIVE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width
- `V_BP`, 33, vertical back porch; V_TOTAL = sum = 525
- `LOCK_SETTLE`, 16, cycles `locked` must stay high before the raster starts

- `clk`  in  1  25 MHz pixel clock (PLL output)
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `locked`  in  1  PLL lock status, synchronous to `clk`
- `req_valid`  out  1  a pixel at (`req_x`, `req_y`) must be fetched this cycle
- `req_x`  out  10  request column, 0..639
- `req_y`  out  9  request row, 0..479
- `frame_start`  out  1  one-cycle pulse together with the request for (0,0)
- `de`  out  1  display enable (active video)
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `running`  out  1  high while the FSM is in RUN

## Operation
- FSM states: WAIT_LOCK, SETTLE, RUN. Reset state: WAIT_LOCK.
- WAIT_LOCK → SETTLE when `locked`=1. The settle counter is cleared.
- SETTLE: the counter increments each cycle while `locked`=1. When it reaches LOCK_SETTLE−1, the FSM moves to RUN. If `locked`=0, the FSM returns to WAIT_LOCK.
- RUN: `h_cnt` counts 0..H_TOTAL−1 and wraps to 0. When `h_cnt` wraps, `v_cnt` increments, and it wraps to 0 after V_TOTAL−1. If `locked`=0, the FSM returns to WAIT_LOCK.
- `locked`=0 in any state has this effect on the next edge:
  - the FSM goes to WAIT_LOCK;
  - the counters clear to 0;
  - all pipeline outputs take their reset values.
- Stage 0 holds the counters (`h_cnt`, `v_cnt`).
- Stage 1 registers the request outputs from stage 0:
  - `req_valid` = RUN && `h_cnt`<H_ACTIVE && `v_cnt`<V_ACTIVE;
  - `req_x`/`req_y` = `h_cnt`/`v_cnt` when valid, else 0;
  - `frame_start` = RUN && `h_cnt`=0 && `v_cnt`=0.
- Stage 2 registers the display outputs from stage 1:
  - `de` = `req_valid` delayed by one cycle;
  - `hsync` = low iff `h_cnt` was in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC−1] = [656,751];
  - `vsync` = low iff `v_cnt` was in [490,491].
- The sync decode is delayed two stages so that `hsync`/`vsync` stay aligned with `de`.
- Counter widths: `h_cnt` is 10 bits and `v_cnt` is 10 bits. Compares are unsigned. No out-of-range values are reachable.

## Timing
- Reset values:
  - FSM: WAIT_LOCK; counters: 0;
  - `req_valid`=0, `req_x`=0, `req_y`=0, `frame_start`=0, `de`=0, `running`=0;
  - `hsync`=1, `vsync`=1.
- `locked` rising at edge E: the FSM is in SETTLE from E+1 and in RUN from E+LOCK_SETTLE. The counters are (0,0) in the first RUN cycle.
- `req_valid`/`frame_start` for (0,0) appear 1 cycle after the counter is (0,0). `de`=1 for (0,0) appears 2 cycles after.
- Latency from request to `de` is exactly 1 cycle for every pixel. The downstream memory read must have 1-cycle latency.
- Each line is 800 cycles: 640 cycles of `de`=1, then 16 front porch, 96 `hsync` low, 48 back porch.
- Each frame is 525 lines = 420 000 cycles. `frame_start` pulses once per frame.
- `running` is registered and changes on the same edge as the FSM state.
- An asynchronous `rst` mid-frame forces all outputs to their reset values immediately. After release, the full WAIT_LOCK/SETTLE sequence repeats.

## Structure
- Package `vga_timing_pkg` holds:
  - the 640×480 timing constants (H_*, V_*, derived H_TOTAL/V_TOTAL, sync start/end);
  - the state enum `vga_state_t`;
  - the `req_x`/`req_y` width constants.
- One sub-module, `wrap_counter`: a parameterised modulus-N counter with an enable input, a synchronous clear, and a wrap pulse. It is instantiated twice: horizontal (enable = RUN) and vertical (enable = horizontal wrap).

## Test plan
- Reset, then `locked`=1 at cycle 10: `running`=1 at cycle 26. First `frame_start`/`req_valid` with (0,0) at cycle 27. `de`=1 at cycle 28.
- Run 2 full frames:
  - exactly 640 `de` cycles per line and 480 active lines per frame (307 200 per frame);
  - `frame_start` period = 420 000 cycles;
  - `hsync` low for 96 cycles starting 16 cycles after the last `de` of a line;
  - `vsync` low for 2×800 cycles starting at line 490.
- Check `req_x`/`req_y` at cycle N against `de` at cycle N+1 for every active pixel. Coordinates must be sequential and wrap 639→0 with `req_y`+1.
- `locked` dips for 1 cycle during SETTLE (cycle 5 of 16): return to WAIT_LOCK. RUN is reached only after 16 further consecutive high cycles.
- `locked` drops mid-frame at (300,200): next edge gives `de`=0, `hsync`=`vsync`=1, `running`=0. On relock, the raster restarts at (0,0).
- Assert `rst` asynchronously mid-line between clock edges: outputs take their reset values before the next edge. The full lock sequence repeats after release.
